// File: rtl/time_set_encoder.sv
// time_set_encoder: HH:MM:SS BCD clock with three-key adjust mode that drives
// an 8-position seven-segment scanner: segment word, blink cursor and adjust flag.
// The FSM is NORMAL (time runs) / ADJUST (time frozen, cursor edits one digit).
// The adjust output is the registered image of the FSM state.
module time_set_encoder #(
  parameter int TICK_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20,
  parameter int TIMEOUT_CYC  = 10000
) (
  input  logic        CP_1KHz,
  input  logic        CR,
  input  logic        key_mode,
  input  logic        key_next,
  input  logic        key_inc,
  output logic [63:0] display_time,
  output logic [3:0]  index,
  output logic        adjust,
  output logic [23:0] time_bcd
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int OW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {ST_NORMAL = 1'b0, ST_ADJUST = 1'b1} state_t;

  // Key bit 0 = mode, 1 = next, 2 = inc.
  logic [2:0]    keys;
  logic [2:0]    sync1, sync2, level, pulse;
  logic [DW-1:0] deb_cnt [3];

  state_t        state_q, state_d;
  logic [TW-1:0] tick_cnt;
  logic [OW-1:0] to_cnt;
  logic          tick_hit, to_hit, any_key;
  logic          p_mode, p_next, p_inc;
  logic          do_tick, do_inc, do_next, cursor_clr;

  logic [3:0]    h1, h0, m1, m0, s1, s0;
  logic [2:0]    cursor_q;

  assign keys = {key_inc, key_next, key_mode};

  // Wrap a BCD digit back to 0 once it has reached its upper limit.
  function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? 4'd0 : v + 4'd1;
  endfunction

  // Cursor walk over the digit positions, skipping the two dash separators.
  function automatic logic [2:0] next_pos(input logic [2:0] p);
    case (p)
      3'd0:    return 3'd1;
      3'd1:    return 3'd3;
      3'd3:    return 3'd4;
      3'd4:    return 3'd6;
      3'd6:    return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  // Active-low segment code {dp,g,f,e,d,c,b,a}; non-BCD values are blank.
  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Per-key synchronizer and debounce; a pulse marks each accepted press.
  always_ff @(posedge CP_1KHz) begin
    if (CR) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      pulse <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        pulse[i] <= 1'b0;
        if (sync2[i] != level[i]) begin
          if (deb_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
            level[i]   <= sync2[i];
            pulse[i]   <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DW'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Same-cycle pulses resolve mode > next > inc; the losers are dropped.
  assign p_mode  = pulse[0];
  assign p_next  = pulse[1] & ~pulse[0];
  assign p_inc   = pulse[2] & ~pulse[1] & ~pulse[0];
  assign any_key = |pulse;

  assign tick_hit = (state_q == ST_NORMAL) && (tick_cnt == TW'(TICK_DIV - 1));
  assign to_hit   = (to_cnt == OW'(TIMEOUT_CYC - 1));

  // FSM state register.
  always_ff @(posedge CP_1KHz) begin
    if (CR) state_q <= ST_NORMAL;
    else    state_q <= state_d;
  end

  // FSM next-state: mode toggles, idle timeout falls back to NORMAL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: if (p_mode) state_d = ST_ADJUST;
      ST_ADJUST: begin
        if (p_mode)                 state_d = ST_NORMAL;
        else if (!any_key && to_hit) state_d = ST_NORMAL;
      end
      default:   state_d = ST_NORMAL;
    endcase
  end

  // FSM output decode: which datapath action fires this cycle.
  always_comb begin
    do_tick    = 1'b0;
    do_inc     = 1'b0;
    do_next    = 1'b0;
    cursor_clr = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        do_tick    = tick_hit & ~p_mode;
        cursor_clr = p_mode;
      end
      ST_ADJUST: begin
        do_inc  = p_inc;
        do_next = p_next;
      end
      default: ;
    endcase
  end

  // 1 s prescaler: runs only while staying in NORMAL, otherwise parked at 0.
  always_ff @(posedge CP_1KHz) begin
    if (CR || state_q != ST_NORMAL || state_d != ST_NORMAL || tick_hit) tick_cnt <= '0;
    else                                                                tick_cnt <= tick_cnt + TW'(1);
  end

  // Idle timer for ADJUST, restarted by every key pulse.
  always_ff @(posedge CP_1KHz) begin
    if (CR || state_q != ST_ADJUST || any_key || to_hit) to_cnt <= '0;
    else                                                 to_cnt <= to_cnt + OW'(1);
  end

  // Time-of-day digits: cascaded tick in NORMAL, carry-free edits in ADJUST.
  always_ff @(posedge CP_1KHz) begin
    if (CR) begin
      {h1, h0, m1, m0, s1, s0} <= '0;
    end else if (do_tick) begin
      if (s0 == 4'd9) begin
        s0 <= 4'd0;
        if (s1 == 4'd5) begin
          s1 <= 4'd0;
          if (m0 == 4'd9) begin
            m0 <= 4'd0;
            if (m1 == 4'd5) begin
              m1 <= 4'd0;
              if (h1 == 4'd2 && h0 == 4'd3) begin
                h1 <= 4'd0;
                h0 <= 4'd0;
              end else if (h0 == 4'd9) begin
                h0 <= 4'd0;
                h1 <= h1 + 4'd1;
              end else begin
                h0 <= h0 + 4'd1;
              end
            end else m1 <= m1 + 4'd1;
          end else m0 <= m0 + 4'd1;
        end else s1 <= s1 + 4'd1;
      end else s0 <= s0 + 4'd1;
    end else if (do_inc) begin
      case (cursor_q)
        3'd0: begin
          h1 <= wrap_inc(h1, 4'd2);
          // Entering the 20s hours: an hour digit above 3 would be illegal.
          if (h1 == 4'd1 && h0 > 4'd3) h0 <= 4'd0;
        end
        3'd1:    h0 <= wrap_inc(h0, (h1 == 4'd2) ? 4'd3 : 4'd9);
        3'd3:    m1 <= wrap_inc(m1, 4'd5);
        3'd4:    m0 <= wrap_inc(m0, 4'd9);
        3'd6:    s1 <= wrap_inc(s1, 4'd5);
        3'd7:    s0 <= wrap_inc(s0, 4'd9);
        default: ;
      endcase
    end
  end

  // Adjust cursor: cleared on entry to ADJUST, holds its value on exit.
  always_ff @(posedge CP_1KHz) begin
    if (CR || cursor_clr) cursor_q <= '0;
    else if (do_next)     cursor_q <= next_pos(cursor_q);
  end

  assign time_bcd = {h1, h0, m1, m0, s1, s0};

  // Registered encode stage: display, cursor and flag trail the core by one cycle.
  always_ff @(posedge CP_1KHz) begin
    if (CR) begin
      display_time <= 64'hC0C0_BFC0_C0BF_C0C0;
      index        <= 4'd0;
      adjust       <= 1'b0;
    end else begin
      display_time <= {seg(h1), seg(h0), 8'hBF, seg(m1), seg(m0), 8'hBF, seg(s1), seg(s0)};
      index        <= {1'b0, cursor_q};
      adjust       <= (state_q == ST_ADJUST);
    end
  end

endmodule

// File: tb/tb_time_set_encoder.sv
// Bench for time_set_encoder: table of key presses with expected time/cursor/flag,
// plus hand-written sequences for rollover, debounce, simultaneous keys, timeout.
module tb_time_set_encoder;

  localparam int KM = 0;
  localparam int KN = 1;
  localparam int KI = 2;
  localparam int W  = 93;  // {time[23:0], adjust, index[3:0], display[63:0]}

  logic        clk = 1'b0;
  logic        cr, km, kn, ki;
  logic [63:0] display_time;
  logic [3:0]  index;
  logic        adjust;
  logic [23:0] time_bcd;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int          key;
    logic [23:0] t;
    logic        a;
    logic [3:0]  i;
  } vec_t;

  vec_t vecs[80];
  int   nv = 0;

  time_set_encoder dut (
    .CP_1KHz      (clk),
    .CR           (cr),
    .key_mode     (km),
    .key_next     (kn),
    .key_inc      (ki),
    .display_time (display_time),
    .index        (index),
    .adjust       (adjust),
    .time_bcd     (time_bcd)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  function automatic logic [7:0] enc_digit(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;
      4'd3: return 8'hB0;  4'd4: return 8'h99;  4'd5: return 8'h92;
      4'd6: return 8'h82;  4'd7: return 8'hF8;  4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] enc_time(input logic [23:0] t);
    return {enc_digit(t[23:20]), enc_digit(t[19:16]), 8'hBF, enc_digit(t[15:12]),
            enc_digit(t[11:8]), 8'hBF, enc_digit(t[7:4]), enc_digit(t[3:0])};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Scoreboard
  task automatic sb_push(input logic [23:0] t, input logic a, input logic [3:0] i);
    exp_q.push_back({t, a, i, enc_time(t)});
  endtask

  task automatic sb_check(input string name);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got empty queue expected an entry", name);
    end else begin
      e = exp_q.pop_front();
      check({name, "_time"}, 64'(time_bcd), 64'(e[92:69]));
      check({name, "_adj"},  64'(adjust),   64'(e[68]));
      check({name, "_idx"},  64'(index),    64'(e[67:64]));
      check({name, "_disp"}, display_time,  e[63:0]);
    end
  endtask

  // Driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic m, input logic n, input logic i, input int hold);
    @(negedge clk);
    km = m; kn = n; ki = i;
    wait_cyc(hold);
    km = 1'b0; kn = 1'b0; ki = 1'b0;
    wait_cyc(30);
  endtask

  task automatic apply_vec(input vec_t v, input string name);
    sb_push(v.t, v.a, v.i);
    press(v.key == KM, v.key == KN, v.key == KI, 30);
    sb_check(name);
  endtask

  task automatic add(input int key, input logic [23:0] t, input logic a, input logic [3:0] i);
    vecs[nv].key = key;
    vecs[nv].t   = t;
    vecs[nv].a   = a;
    vecs[nv].i   = i;
    nv++;
  endtask

  initial begin
    int   n;
    vec_t v;

    cr = 1'b1; km = 1'b0; kn = 1'b0; ki = 1'b0;

    // Adjust flow: H1 steps, full cursor walk
    add(KM, 24'h000000, 1, 0);
    add(KI, 24'h100000, 1, 0);
    add(KI, 24'h200000, 1, 0);
    add(KI, 24'h000000, 1, 0);
    add(KN, 24'h000000, 1, 1);
    add(KN, 24'h000000, 1, 3);
    add(KN, 24'h000000, 1, 4);
    add(KN, 24'h000000, 1, 6);
    add(KN, 24'h000000, 1, 7);
    add(KN, 24'h000000, 1, 0);
    // Build 17:00:00, then the hour clamp
    add(KI, 24'h100000, 1, 0);
    add(KN, 24'h100000, 1, 1);
    for (int k = 1; k <= 7; k++) add(KI, 24'h100000 + (24'(k) << 16), 1, 1);
    add(KN, 24'h170000, 1, 3);
    add(KN, 24'h170000, 1, 4);
    add(KN, 24'h170000, 1, 6);
    add(KN, 24'h170000, 1, 7);
    add(KN, 24'h170000, 1, 0);
    add(KI, 24'h200000, 1, 0);
    // H0 limited to 3 while H1 = 2, then build 23:59:59
    add(KN, 24'h200000, 1, 1);
    add(KI, 24'h210000, 1, 1);
    add(KI, 24'h220000, 1, 1);
    add(KI, 24'h230000, 1, 1);
    add(KI, 24'h200000, 1, 1);
    add(KI, 24'h210000, 1, 1);
    add(KI, 24'h220000, 1, 1);
    add(KI, 24'h230000, 1, 1);
    add(KN, 24'h230000, 1, 3);
    for (int k = 1; k <= 5; k++) add(KI, 24'h230000 + (24'(k) << 12), 1, 3);
    add(KN, 24'h235000, 1, 4);
    for (int k = 1; k <= 9; k++) add(KI, 24'h235000 + (24'(k) << 8), 1, 4);
    add(KN, 24'h235900, 1, 6);
    for (int k = 1; k <= 5; k++) add(KI, 24'h235900 + (24'(k) << 4), 1, 6);
    add(KN, 24'h235950, 1, 7);
    for (int k = 1; k <= 9; k++) add(KI, 24'h235950 + 24'(k), 1, 7);
    add(KM, 24'h235959, 0, 7);

    // Reset
    wait_cyc(2);
    sb_push(24'h000000, 1'b0, 4'd0);
    sb_check("reset");
    cr = 1'b0;

    for (int k = 0; k < nv; k++) apply_vec(vecs[k], $sformatf("vec%0d", k));

    // Rollover 23:59:59 -> 00:00:00, display one cycle later
    n = 0;
    while (time_bcd === 24'h235959 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    check_range("tick_wait", n, 940, 990);
    check("roll_time", 64'(time_bcd), 64'(24'h000000));
    check("roll_disp_before", display_time, enc_time(24'h235959));
    @(negedge clk);
    check("roll_disp_after", display_time, enc_time(24'h000000));

    // Debounce: glitch, short hold, long hold
    v.key = KM; v.t = 24'h000000; v.a = 1'b1; v.i = 4'd0;
    apply_vec(v, "enter_adj");
    sb_push(24'h000000, 1'b1, 4'd0);
    press(1'b0, 1'b0, 1'b1, 15);
    sb_check("glitch15");
    sb_push(24'h100000, 1'b1, 4'd0);
    press(1'b0, 1'b0, 1'b1, 25);
    sb_check("hold25");
    sb_push(24'h200000, 1'b1, 4'd0);
    press(1'b0, 1'b0, 1'b1, 5000);
    sb_check("hold5000");

    // Mode and inc together: only the mode action occurs
    sb_push(24'h200000, 1'b0, 4'd0);
    press(1'b1, 1'b0, 1'b1, 30);
    sb_check("simul_adj");
    sb_push(24'h200000, 1'b1, 4'd0);
    press(1'b1, 1'b0, 1'b1, 30);
    sb_check("simul_norm");

    // Idle timeout back to NORMAL, then time resumes
    n = 0;
    while (adjust === 1'b1 && n < 10200) begin
      @(negedge clk);
      n++;
    end
    check_range("timeout_wait", n, 9900, 10010);
    check("timeout_adj", 64'(adjust), 64'(1'b0));
    check("timeout_frozen", 64'(time_bcd), 64'(24'h200000));
    n = 0;
    while (time_bcd === 24'h200000 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    check_range("resume_wait", n, 990, 1005);
    check("resume_time", 64'(time_bcd), 64'(24'h200001));

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
